// File: rtl/keypad_bcd_entry.sv
// Keypad digit-entry controller: registers and debounces a one-hot keypad code,
// builds a BCD entry and commits it on ENTER.
module keypad_bcd_entry #(
  parameter int NUM_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SHIFT_MODE      = 0,
  localparam int CW = $clog2(NUM_DIGITS + 1),
  localparam int BW = 4 * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   onehot,
  output logic [BW-1:0] bcd,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          key_valid,
  output logic [3:0]    key_digit,
  output logic          overflow,
  output logic          done,
  output logic [BW-1:0] result
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);
  // The IDLE sample already counts as the first stable sample of a press.
  localparam logic [7:0] PRESS_LOAD = 8'(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [7:0] REL_LOAD   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] K_CLEAR = 4'd10;
  localparam logic [3:0] K_BACK  = 4'd11;
  localparam logic [3:0] K_ENTER = 4'd12;

  state_t          state_q, state_d;
  logic [15:0]     key_q;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;
  logic [BW-1:0]   bcd_q, bcd_d, result_q, result_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      key_digit_q, key_digit_d;
  logic            key_valid_q, key_valid_d, overflow_q, overflow_d, done_q, done_d;
  logic            in_vld, fire;
  logic [3:0]      in_code;

  always_comb begin
    in_vld  = 1'b1;
    in_code = 4'd0;
    case (key_q)
      16'h0008: in_code = 4'd0;
      16'h0080: in_code = 4'd1;
      16'h0040: in_code = 4'd2;
      16'h0020: in_code = 4'd3;
      16'h0800: in_code = 4'd4;
      16'h0400: in_code = 4'd5;
      16'h0200: in_code = 4'd6;
      16'h8000: in_code = 4'd7;
      16'h4000: in_code = 4'd8;
      16'h2000: in_code = 4'd9;
      16'h0001: in_code = K_CLEAR;
      16'h0002: in_code = K_BACK;
      16'h0004: in_code = K_ENTER;
      default:  in_vld  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: if (in_vld) begin
        code_d = in_code;
        if (DEBOUNCE_CYCLES == 1) begin
          fire    = 1'b1;
          state_d = HELD;
        end else begin
          state_d = PRESS_DB;
          cnt_d   = PRESS_LOAD;
        end
      end
      PRESS_DB: begin
        if (!in_vld) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (in_code != code_q) begin
          code_d = in_code;
          cnt_d  = PRESS_LOAD;
        end else if (cnt_q == 8'd0) begin
          fire    = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HELD: if (!in_vld) begin
        state_d = REL_DB;
        cnt_d   = REL_LOAD;
      end
      REL_DB: begin
        if (in_vld) begin
          state_d = HELD;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // On a firing edge in_code is the debounced key in both firing paths.
  always_comb begin
    bcd_d       = bcd_q;
    count_d     = count_q;
    result_d    = result_q;
    key_digit_d = key_digit_q;
    key_valid_d = 1'b0;
    overflow_d  = 1'b0;
    done_d      = 1'b0;
    if (fire) begin
      if (in_code <= 4'd9) begin
        if (count_q == FULL_CNT) begin
          overflow_d = 1'b1;
        end else begin
          if (SHIFT_MODE == 0) bcd_d[4*count_q +: 4] = in_code;
          else                 bcd_d = (bcd_q << 4) | BW'(in_code);
          count_d     = count_q + 1'b1;
          key_valid_d = 1'b1;
          key_digit_d = in_code;
        end
      end else if (in_code == K_CLEAR) begin
        bcd_d   = '0;
        count_d = '0;
      end else if (in_code == K_BACK) begin
        if (count_q != '0) begin
          if (SHIFT_MODE == 0) bcd_d[4*(count_q - 1'b1) +: 4] = 4'd0;
          else                 bcd_d = bcd_q >> 4;
          count_d = count_q - 1'b1;
        end
      end else if (count_q != '0) begin
        result_d = bcd_q;
        bcd_d    = '0;
        count_d  = '0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      bcd_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
      key_digit_q <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= onehot;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      result_q    <= result_d;
      key_digit_q <= key_digit_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign bcd       = bcd_q;
  assign count     = count_q;
  assign full      = (count_q == FULL_CNT);
  assign key_valid = key_valid_q;
  assign key_digit = key_digit_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule
